// File: rtl/pia6821_resp.sv
// rtl/pia6821_resp.sv - 6821-style PIA bus responder for the cpu09 core
// Define PIA_C2_IRQ_EN to enable C2 input-mode edge flags and interrupts.
module pia6821_resp (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       vma,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  input  logic       ca1,
  input  logic       cb1,
  input  logic       ca2_in,
  input  logic       cb2_in,
  output logic       ca2_out,
  output logic       cb2_out,
  output logic       irqa_n,
  output logic       irqb_n
);
  logic            rd_acc, wr_acc;
  logic            init_q, init_d;
  logic [1:0][5:0] cr_q, cr_d;
  logic [1:0][7:0] ddr_q, ddr_d, or_q, or_d;
  logic [1:0][7:0] pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
  logic [1:0]      c1_s1_q, c1_s1_d, c1_s2_q, c1_s2_d, c1_prev_q, c1_prev_d;
  logic [1:0]      flag1_q, flag1_d;
  logic [1:0]      flag2;
  logic [1:0]      clr_rd;
  logic [1:0][7:0] pin;
  logic [1:0]      c1_pin;

  assign rd_acc = cs & vma & ~rw;
  assign wr_acc = cs & vma & rw;
  assign pin    = {pb_in, pa_in};
  assign c1_pin = {cb1, ca1};
  assign clr_rd[0] = rd_acc & (addr == 2'd0) & cr_q[0][2];
  assign clr_rd[1] = rd_acc & (addr == 2'd2) & cr_q[1][2];

  // init_q is low for the first clock after reset; synchronizers load the live pin level then.
  always_comb begin
    init_d    = 1'b1;
    cr_d      = cr_q;
    ddr_d     = ddr_q;
    or_d      = or_q;
    pin_s1_d  = pin;
    pin_s2_d  = init_q ? pin_s1_q : pin;
    c1_s1_d   = c1_pin;
    c1_s2_d   = init_q ? c1_s1_q : c1_pin;
    c1_prev_d = init_q ? c1_s2_q : c1_pin;
    for (int i = 0; i < 2; i++) begin
      flag1_d[i] = (init_q & (cr_q[i][1] ? (c1_s2_q[i] & ~c1_prev_q[i])
                                         : (~c1_s2_q[i] & c1_prev_q[i])))
                 | (flag1_q[i] & ~clr_rd[i]);
      if (wr_acc && (addr[1] == 1'(i))) begin
        if (addr[0])         cr_d[i]  = data_in[5:0];
        else if (cr_q[i][2]) or_d[i]  = data_in;
        else                 ddr_d[i] = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q    <= 1'b0;
      cr_q      <= '0;
      ddr_q     <= '0;
      or_q      <= '0;
      pin_s1_q  <= '0;
      pin_s2_q  <= '0;
      c1_s1_q   <= '0;
      c1_s2_q   <= '0;
      c1_prev_q <= '0;
      flag1_q   <= '0;
    end else begin
      init_q    <= init_d;
      cr_q      <= cr_d;
      ddr_q     <= ddr_d;
      or_q      <= or_d;
      pin_s1_q  <= pin_s1_d;
      pin_s2_q  <= pin_s2_d;
      c1_s1_q   <= c1_s1_d;
      c1_s2_q   <= c1_s2_d;
      c1_prev_q <= c1_prev_d;
      flag1_q   <= flag1_d;
    end
  end

`ifdef PIA_C2_IRQ_EN
  logic [1:0] c2_pin, c2_s1_q, c2_s1_d, c2_s2_q, c2_s2_d, c2_prev_q, c2_prev_d;
  logic [1:0] flag2_q, flag2_d;

  assign c2_pin = {cb2_in, ca2_in};
  assign flag2  = flag2_q;

  always_comb begin
    c2_s1_d   = c2_pin;
    c2_s2_d   = init_q ? c2_s1_q : c2_pin;
    c2_prev_d = init_q ? c2_s2_q : c2_pin;
    for (int i = 0; i < 2; i++) begin
      flag2_d[i] = (init_q & ~cr_q[i][5] & (cr_q[i][4] ? (c2_s2_q[i] & ~c2_prev_q[i])
                                                       : (~c2_s2_q[i] & c2_prev_q[i])))
                 | (flag2_q[i] & ~clr_rd[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c2_s1_q   <= '0;
      c2_s2_q   <= '0;
      c2_prev_q <= '0;
      flag2_q   <= '0;
    end else begin
      c2_s1_q   <= c2_s1_d;
      c2_s2_q   <= c2_s2_d;
      c2_prev_q <= c2_prev_d;
      flag2_q   <= flag2_d;
    end
  end
`else
  logic unused_c2;
  assign unused_c2 = ca2_in ^ cb2_in;
  assign flag2     = 2'b00;
`endif

  always_comb begin
    data_out = 8'h00;
    if (rd_acc) begin
      case (addr)
        2'd0:    data_out = cr_q[0][2] ? pin_s2_q[0] : ddr_q[0];
        2'd1:    data_out = {flag1_q[0], flag2[0], cr_q[0]};
        2'd2:    data_out = cr_q[1][2] ? ((or_q[1] & ddr_q[1]) | (pin_s2_q[1] & ~ddr_q[1]))
                                       : ddr_q[1];
        default: data_out = {flag1_q[1], flag2[1], cr_q[1]};
      endcase
    end
  end

  assign pa_out  = or_q[0];
  assign pb_out  = or_q[1];
  assign pa_oe   = ddr_q[0];
  assign pb_oe   = ddr_q[1];
  assign ca2_out = cr_q[0][5] ? cr_q[0][3] : 1'b1;
  assign cb2_out = cr_q[1][5] ? cr_q[1][3] : 1'b1;
  assign irqa_n  = ~((flag1_q[0] & cr_q[0][0]) | (flag2[0] & cr_q[0][3] & ~cr_q[0][5]));
  assign irqb_n  = ~((flag1_q[1] & cr_q[1][0]) | (flag2[1] & cr_q[1][3] & ~cr_q[1][5]));
endmodule
